// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word widths, the four control tokens and the channel FSM states.
package tmds_pkg;

  localparam int unsigned TmdsWidth = 10;
  localparam int unsigned DataWidth = 8;

  localparam logic [TmdsWidth-1:0] TokenCtrl00 = 10'b1101010100;
  localparam logic [TmdsWidth-1:0] TokenCtrl01 = 10'b0010101011;
  localparam logic [TmdsWidth-1:0] TokenCtrl10 = 10'b0101010100;
  localparam logic [TmdsWidth-1:0] TokenCtrl11 = 10'b1010101011;

  typedef enum logic [1:0] {
    StSearch,
    StSlip,
    StLocked
  } state_e;

endpackage

// File: rtl/tmds_10b8b_decode.sv
// Combinational TMDS 10b -> 8b decode: classifies control tokens and undoes the
// transition-minimising / DC-balancing encoding for data words.
module tmds_10b8b_decode
  import tmds_pkg::*;
(
  input  logic [TmdsWidth-1:0] din_i,
  output logic                 is_token_o,
  output logic [1:0]           ctrl_o,
  output logic [DataWidth-1:0] data_o
);

  logic [DataWidth-1:0] q;

  always_comb begin
    is_token_o = 1'b1;
    ctrl_o     = 2'b00;
    unique case (din_i)
      TokenCtrl00: ctrl_o = 2'b00;
      TokenCtrl01: ctrl_o = 2'b01;
      TokenCtrl10: ctrl_o = 2'b10;
      TokenCtrl11: ctrl_o = 2'b11;
      default:     is_token_o = 1'b0;
    endcase
  end

  // Bit 9 flags inversion for DC balance; bit 8 selects XOR vs XNOR chaining.
  always_comb begin
    q         = din_i[TmdsWidth-1] ? ~din_i[DataWidth-1:0] : din_i[DataWidth-1:0];
    data_o    = '0;
    data_o[0] = q[0];
    for (int i = 1; i < DataWidth; i++) begin
      data_o[i] = din_i[DataWidth] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder_channel.sv
// One TMDS receive channel: hunts for control-token runs to align the word boundary
// (requesting bitslips from the deserializer), then decodes words to pixel/control data.
module tmds_decoder_channel
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_WIN   = 1024,
  parameter int unsigned TOKEN_RUN    = 16,
  parameter int unsigned SLIP_WAIT    = 4,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic [TmdsWidth-1:0] din,
  output logic                 bitslip,
  output logic                 locked,
  output logic [3:0]           slip_cnt,
  output logic                 vde,
  output logic [1:0]           ctrl,
  output logic [DataWidth-1:0] dout
);

  localparam int unsigned WinW  = (SEARCH_WIN > 1) ? $clog2(SEARCH_WIN) : 1;
  localparam int unsigned RunW  = $clog2(TOKEN_RUN + 1);
  localparam int unsigned WaitW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int unsigned ToW   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [WinW-1:0]  WinLast  = WinW'(SEARCH_WIN - 1);
  localparam logic [RunW-1:0]  RunFull  = RunW'(TOKEN_RUN);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(LOCK_TIMEOUT - 1);

  logic                 is_token;
  logic [1:0]           tok_ctrl;
  logic [DataWidth-1:0] dec_data;

  tmds_10b8b_decode u_decode (
    .din_i      (din),
    .is_token_o (is_token),
    .ctrl_o     (tok_ctrl),
    .data_o     (dec_data)
  );

  state_e               state_q, state_d;
  logic [TmdsWidth-1:0] prev_q;
  logic [RunW-1:0]      run_q, run_d;
  logic [WinW-1:0]      win_q, win_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic [ToW-1:0]       to_q, to_d;
  logic [3:0]           slip_q, slip_d;
  logic                 vde_q, vde_d;
  logic [1:0]           ctrl_q, ctrl_d;
  logic [DataWidth-1:0] dout_q, dout_d;
  logic                 run_full;

  // Run length includes the current word so lock can be declared on the completing word.
  always_comb begin
    run_d = '0;
    if (state_q != StSlip && is_token) begin
      if (din == prev_q) begin
        run_d = (run_q == RunFull) ? run_q : run_q + 1'b1;
      end else begin
        run_d = RunW'(1);
      end
    end
  end

  assign run_full = (run_d == RunFull);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    wait_d  = wait_q;
    to_d    = to_q;
    slip_d  = slip_q;
    bitslip = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (run_full) begin
          state_d = StLocked;
          to_d    = '0;
          win_d   = '0;
        end else if (win_q == WinLast) begin
          bitslip = 1'b1;
          slip_d  = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
          win_d   = '0;
          wait_d  = '0;
          state_d = StSlip;
        end else begin
          win_d = win_q + 1'b1;
        end
      end
      StSlip: begin
        if (wait_q == WaitLast) begin
          wait_d  = '0;
          state_d = StSearch;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StLocked: begin
        if (run_full) begin
          to_d = '0;
        end else if (to_q == ToLast) begin
          state_d = StSearch;
          slip_d  = '0;
          win_d   = '0;
          to_d    = '0;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
  end

  always_comb begin
    vde_d  = 1'b0;
    ctrl_d = ctrl_q;
    dout_d = '0;
    if (state_q != StLocked) begin
      ctrl_d = 2'b00;
    end else if (is_token) begin
      ctrl_d = tok_ctrl;
    end else begin
      vde_d  = 1'b1;
      dout_d = dec_data;
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= StSearch;
      prev_q  <= '0;
      run_q   <= '0;
      win_q   <= '0;
      wait_q  <= '0;
      to_q    <= '0;
      slip_q  <= '0;
      vde_q   <= 1'b0;
      ctrl_q  <= 2'b00;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= din;
      run_q   <= run_d;
      win_q   <= win_d;
      wait_q  <= wait_d;
      to_q    <= to_d;
      slip_q  <= slip_d;
      vde_q   <= vde_d;
      ctrl_q  <= ctrl_d;
      dout_q  <= dout_d;
    end
  end

  assign locked   = (state_q == StLocked);
  assign slip_cnt = slip_q;
  assign vde      = vde_q;
  assign ctrl     = ctrl_q;
  assign dout     = dout_q;

endmodule
